// File: rtl/message_pkg.sv
`default_nettype none
// ============================================================================
// Module      : message_pkg
// Description : Shared frame constants, FSM state type and the 8-bit
//               modulo-256 byte-sum helper for the message frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
package message_pkg;

  localparam int         FRAME_BYTES = 5;      // cluster0..3 + csum_cluster
  localparam int         DATA_BYTES  = 4;      // bytes forwarded downstream
  localparam logic [7:0] CSUM_OK     = 8'h00;  // sum of a good frame

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  // Modulo-256 sum of two bytes; the carry out is deliberately dropped.
  function automatic logic [7:0] byte_sum(input logic [7:0] a,
                                          input logic [7:0] b);
    return a + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/message_csum_acc.sv
`default_nettype none
// ============================================================================
// Module      : message_csum_acc
// Description : 8-bit modulo-256 checksum accumulator with clear and
//               add-enable. sum_zero flags that the running sum plus the
//               byte currently on din would equal CSUM_OK, so the verdict for
//               the final (checksum) byte is available on the same cycle the
//               byte is accepted.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               clear        - return the accumulator to zero (wins over add)
//               add_en       - add din into the accumulator
//               din [7:0]    - byte to add
//               sum [7:0]    - current accumulator value
//               sum_zero     - (sum + din) mod 256 == CSUM_OK
// Revision    : 1.0 - initial release
// ============================================================================
module message_csum_acc
  import message_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] din,
  output logic [7:0] sum,
  output logic       sum_zero
);

  logic [7:0] w_sum_next;

  assign w_sum_next = byte_sum(sum, din);
  assign sum_zero   = (w_sum_next == CSUM_OK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= 8'h00;
    end else if (clear) begin
      sum <= 8'h00;
    end else if (add_en) begin
      sum <= w_sum_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/message_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : message_frame_ctrl
// Description : Assembles 5-byte frames (cluster0..3, csum_cluster) from a
//               valid/ready byte stream, forwards checksum-good frames as a
//               32-bit word on a valid/ready output, and drops and counts bad
//               frames in a saturating counter.
// Build macro : FRAME_TIMEOUT_EN - when defined, a partial frame that sees
//               TIMEOUT_CYC consecutive cycles without a transfer is
//               discarded and counted as a bad frame.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               in_data/valid/ready   - byte input handshake
//               out_data/valid/ready  - frame output handshake,
//                                       cluster0 in out_data[31:24]
//               frame_err        - one-cycle pulse per bad frame
//               err_cnt          - saturating bad-frame count
//               busy             - not idle in COLLECT with byte index 0
// Revision    : 1.0 - initial release
// ============================================================================
module message_frame_ctrl
  import message_pkg::*;
#(
  parameter int ERR_CNT_W   = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  localparam logic [2:0] C_LAST_IDX = 3'(FRAME_BYTES - 1);

  // A zero or negative timeout would make the counter compare meaningless.
  if (TIMEOUT_CYC < 1) begin : g_timeout_check
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_idx;
  logic [7:0] r_slot [DATA_BYTES];
  logic       r_sum_ok;

  logic       w_xfer;
  logic       w_last;
  logic       w_check_bad;
  logic       w_timeout_hit;
  logic       w_acc_clear;
  logic       w_acc_add;
  logic       w_sum_zero;
  logic [7:0] w_acc_sum;

  assign in_ready    = (r_state == COLLECT);
  assign w_xfer      = in_valid && in_ready;
  assign w_last      = (r_idx == C_LAST_IDX);
  assign w_check_bad = (r_state == CHECK) && !r_sum_ok;
  assign frame_err   = w_check_bad || w_timeout_hit;
  assign busy        = !((r_state == COLLECT) && (r_idx == 3'd0));

  // The checksum byte is never added: its verdict is taken from sum_zero on
  // the accepting cycle and the accumulator is cleared for the next frame.
  assign w_acc_clear = (w_xfer && w_last) || w_timeout_hit;
  assign w_acc_add   = w_xfer && !w_last;

  message_csum_acc u_csum_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_acc_clear),
    .add_en   (w_acc_add),
    .din      (in_data),
    .sum      (w_acc_sum),
    .sum_zero (w_sum_zero)
  );

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] C_TO_FIRE = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_to_cnt;

  // Fires on the TIMEOUT_CYC-th idle cycle of a partial frame; a transfer on
  // that same cycle suppresses it and the byte is taken instead.
  assign w_timeout_hit = (r_state == COLLECT) && (r_idx != 3'd0) &&
                         !w_xfer && (r_to_cnt == C_TO_FIRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_xfer || (r_state != COLLECT) || (r_idx == 3'd0) ||
                 w_timeout_hit) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: if (w_xfer && w_last)         w_state_next = CHECK;
      CHECK:   w_state_next = r_sum_ok ? OUTPUT : COLLECT;
      OUTPUT:  if (out_valid && out_ready)   w_state_next = COLLECT;
      default: w_state_next = COLLECT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Byte index, slots and checksum verdict
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= 3'd0;
      r_sum_ok <= 1'b0;
    end else if (w_timeout_hit) begin
      r_idx    <= 3'd0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_idx    <= 3'd0;
        r_sum_ok <= w_sum_zero;
      end else begin
        r_idx    <= r_idx + 3'd1;
      end
    end
  end

  // Slots carry no reset: they are only observable through out_data, which
  // is loaded from them after a complete frame has been written.
  always_ff @(posedge clk) begin
    if (w_xfer && !w_last) begin
      r_slot[r_idx[1:0]] <= in_data;
    end
  end

  // --------------------------------------------------------------------------
  // Output register and error counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 32'h0;
    end else if ((r_state == CHECK) && r_sum_ok) begin
      out_valid <= 1'b1;
      out_data  <= {r_slot[0], r_slot[1], r_slot[2], r_slot[3]};
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (frame_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_message_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_message_frame_ctrl
// Description : Self-checking bench for message_frame_ctrl. Expected output
//               words are queued as frames are sent; a monitor pops and
//               compares on every output handshake. A second instance with a
//               2-bit error counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_message_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [31:0] out_data;
  logic        out_valid, out_ready;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        busy;

  logic        in_valid2, in_ready2;
  logic [31:0] out_data2;
  logic        out_valid2, out_ready2;
  logic        frame_err2;
  logic [1:0]  err_cnt2;
  logic        busy2;

  always #5 clk = ~clk;

  message_frame_ctrl #(.ERR_CNT_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
  );

  message_frame_ctrl #(.ERR_CNT_W(2), .TIMEOUT_CYC(16)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .frame_err(frame_err2), .err_cnt(err_cnt2), .busy(busy2)
  );

  int          checks = 0;
  int          passes = 0;
  int          err_pulses = 0;
  int          err_pulses2 = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: output handshakes and frame_err pulses are observed on the
  // falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err)  err_pulses++;
      if (frame_err2) err_pulses2++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_data, 32'hxxxx_xxxx);
        else check("out_data", out_data, exp_q.pop_front());
      end
      if (out_valid2 && out_ready2) check("sat_unexpected_out", out_data2, 32'hxxxx_xxxx);
    end
  end

  // Drive one byte to the selected instance; called at posedge+1, returns
  // at posedge+1 after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit sel);
    int n = 0;
    in_data = b;
    if (sel) in_valid2 = 1'b1; else in_valid = 1'b1;
    @(negedge clk);
    while (!(sel ? in_ready2 : in_ready) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!(sel ? in_ready2 : in_ready)) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f, input bit sel);
    for (int i = 4; i >= 0; i--) send_byte(f[i*8 +: 8], sel);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      n++;
      @(posedge clk);
    end
    #1;
    check("drain_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_valid2 = 1'b0;
    out_ready = 1'b1; out_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  out_data, 32'h0);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_err_cnt",   {24'd0, err_cnt}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: good frame
    exp_q.push_back(32'h50726F6A);
    send_frame(40'h50_72_6F_6A_65, 1'b0);
    drain();
    check("t1_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("t1_pulses",  err_pulses, 32'd0);

    // 2: bad frame (sum 0x3A), then good frame
    send_frame(40'h20_C1_1B_A2_9C, 1'b0);
    idle(3);
    check("t2_err_cnt", {24'd0, err_cnt}, 32'd1);
    check("t2_pulses",  err_pulses, 32'd1);
    exp_q.push_back(32'h6F622100);
    send_frame(40'h6F_62_21_00_0E, 1'b0);
    drain();

    // 3: backpressure holds the frame and blocks input
    out_ready = 1'b0;
    exp_q.push_back(32'h65637420);
    send_frame(40'h65_63_74_20_A4, 1'b0);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t3_hold_data",  out_data, 32'h65637420);
      check("t3_in_ready",   {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    check("t3_in_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 4: reset mid-frame discards the partial frame
    send_byte(8'h32, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h69, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_busy_rst", {31'd0, busy}, 32'd0);
    check("t4_err_rst",  {24'd0, err_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(32'h32206973);
    send_frame(40'h32_20_69_73_D2, 1'b0);
    drain();
    check("t4_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("t4_pulses",  err_pulses, 32'd1);

    // 4b: reset during OUTPUT drops out_valid asynchronously
    out_ready = 1'b0;
    send_frame(40'h65_63_74_20_A4, 1'b0);
    wait_out_valid();
    #2;
    rst_n = 1'b0;
    #1;
    check("t4b_valid_drop", {31'd0, out_valid}, 32'd0);
    check("t4b_data_clear", out_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(4);

    // 5: 2-bit counter saturates at 3; every bad frame still pulses
    for (int i = 0; i < 5; i++) send_frame(40'h01_00_00_00_00, 1'b1);
    idle(3);
    check("t5_err_cnt_sat", {30'd0, err_cnt2}, 32'd3);
    check("t5_pulses",      err_pulses2, 32'd5);
    idle(5);
    check("t5_err_cnt_hold", {30'd0, err_cnt2}, 32'd3);

    // 6: idle gap mid-frame
    send_byte(8'h68, 1'b0); send_byte(8'h61, 1'b0);
    idle(20);
`ifdef FRAME_TIMEOUT_EN
    check("t6_to_err_cnt", {24'd0, err_cnt}, 32'd1);
    check("t6_to_pulses",  err_pulses, 32'd2);
    check("t6_to_idle",    {31'd0, busy}, 32'd0);
    exp_q.push_back(32'h68617264);
    send_frame(40'h68_61_72_64_61, 1'b0);
`else
    check("t6_wait_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("t6_wait_pulses",  err_pulses, 32'd1);
    check("t6_wait_busy",    {31'd0, busy}, 32'd1);
    exp_q.push_back(32'h68617264);
    send_byte(8'h72, 1'b0); send_byte(8'h64, 1'b0); send_byte(8'h61, 1'b0);
`endif
    drain();
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/message_frame_ctrl.md
Name: message_frame_ctrl

Overview:
Sequencer in front of the message checksum datapath. Takes a serial byte stream with a valid/ready handshake and assembles 5-byte frames: cluster0..3, then csum_cluster. It checks each frame, forwards good frames as a 32-bit word over a valid/ready output, and drops and counts bad frames. Sits between the byte receiver and the downstream ASCII/message consumer.

Parameters:
ERR_CNT_W, 8, width of the saturating bad-frame counter
TIMEOUT_CYC, 16, idle cycles mid-frame before the partial frame is discarded (used only with FRAME_TIMEOUT_EN)

Ports:
clk  in  1  single clock; all state changes on the rising edge
rst_n  in  1  asynchronous, active-low reset
in_data  in  8  incoming byte
in_valid  in  1  in_data is valid
in_ready  out  1  block accepts a byte this cycle
out_data  out  32  {cluster0, cluster1, cluster2, cluster3}, with cluster0 in [31:24]
out_valid  out  1  out_data holds a checksum-good frame
out_ready  in  1  downstream accepts out_data
frame_err  out  1  one-cycle pulse when a frame fails its checksum
err_cnt  out  ERR_CNT_W  saturating count of bad frames
busy  out  1  high whenever the state is not COLLECT with byte index 0

Behaviour:
- Reset (async assert, sync release): state COLLECT, idx=0, accumulator=0, out_valid=0, out_data=0, frame_err=0, err_cnt=0, in_ready=1.
- A byte transfers when in_valid && in_ready.
- Checksum rule: the frame is good when the 8-bit modulo-256 sum of all 5 bytes is 0x00. Equivalently, csum is the two's complement of the sum of the 4 data bytes.
- COLLECT:
  - in_ready=1.
  - Each transfer stores the byte into slot idx (0..3), adds it to the accumulator, and increments idx.
  - On the transfer with idx==4 (the csum byte), the final sum is computed and the state moves to CHECK next cycle. idx returns to 0 and the accumulator clears.
- CHECK (1 cycle): in_ready=0.
  - Sum==0: load out_data from slots 0..3, set out_valid=1, go to OUTPUT.
  - Sum!=0: pulse frame_err for this cycle, increment err_cnt (saturating at all-ones), go to COLLECT. Slots are not forwarded.
- OUTPUT: in_ready=0; out_valid and out_data are held stable until out_ready.
  - On out_valid && out_ready: out_valid=0 next cycle, go to COLLECT.
- Latency: csum byte accepted at edge N → out_valid high after edge N+1. Minimum frame period is 7 cycles with out_ready held high.
- Backpressure: while out_valid=1 and out_ready=0, no input is accepted and the frame is not lost.
- err_cnt at saturation: stays at all-ones; frame_err still pulses.
- Reset mid-frame or mid-OUTPUT: the partial or pending frame is discarded immediately and out_valid drops asynchronously.
- in_valid is not required to be contiguous; gaps of any length are legal.

Optional Feature:
FRAME_TIMEOUT_EN
- Defined:
  - In COLLECT with idx!=0, a counter increments on each cycle without a transfer and clears on every transfer.
  - When the counter reaches TIMEOUT_CYC: idx=0, accumulator=0, frame_err pulses one cycle, err_cnt increments.
  - A transfer in the same cycle as the timeout wins: no timeout, and the byte is taken.
- Undefined: no counter; a partial frame waits indefinitely; TIMEOUT_CYC is unused.

Decomposition:
- Package message_pkg:
  - FRAME_BYTES=5, DATA_BYTES=4, CSUM_OK=8'h00
  - state enum {COLLECT, CHECK, OUTPUT}
  - helper function for the 8-bit byte sum
- Sub-module message_csum_acc: 8-bit accumulator with clear, add-enable, and a zero-flag output. It is instantiated once.

Test Plan:
1. Bytes 50,72,6F,6A,65 (hex), out_ready=1 → out_valid pulses once with out_data=32'h50726F6A; frame_err=0; err_cnt=0.
2. Bytes 20,C1,1B,A2,9C (sum 3A) → no out_valid, one frame_err pulse, err_cnt=1. Then frame 6F,62,21,00,0E → out_data=32'h6F622100.
3. Backpressure: good frame 65,63,74,20,A4 with out_ready=0 for 10 cycles → out_valid and out_data=32'h65637420 held stable, in_ready=0. After out_ready=1, one transfer completes and in_ready returns to 1.
4. Reset asserted after 3 bytes of 32,20,69,73,D2, then the full frame is sent → only the full frame is output (32'h32206973); no error counted.
5. ERR_CNT_W=2 with 5 consecutive bad frames → err_cnt=3 and held there; 5 frame_err pulses.
6. With FRAME_TIMEOUT_EN, TIMEOUT_CYC=16: 2 bytes, then 16 idle cycles → frame_err pulse, err_cnt=1, idx reset. Next good frame 68,61,72,64,61 → out_data=32'h68617264.
